// File: rtl/fir_seq_pkg.sv
// Shared types for the FIR tap sequencer: FSM state encoding and tap-index width helper.
package fir_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ACCUM,
        ST_CAPTURE,
        ST_OUT
    } state_e;

    // Width of a tap index / coefficient address for a filter of n taps.
    function automatic int unsigned tap_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Circular sample store: write at the head pointer, read by tap offset (tap 0 = newest sample).
module fir_delay_line
    import fir_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NTAPS = 8,
    localparam int TW = tap_w(NTAPS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic signed [WIDTH-1:0] wr_data,
    input  logic [TW-1:0]           rd_tap,
    output logic signed [WIDTH-1:0] rd_data
);

    logic signed [WIDTH-1:0] mem_q [NTAPS];
    logic signed [WIDTH-1:0] mem_d [NTAPS];
    logic [TW-1:0]           head_q, head_d;
    logic [TW:0]             rd_sum;
    logic [TW-1:0]           rd_idx;

    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        if (wr_en) begin
            mem_d[head_q] = wr_data;
            head_d = (head_q == TW'(NTAPS - 1)) ? '0 : head_q + 1'b1;
        end
    end

    // Newest sample sits at head-1; tap k is k slots further back, modulo NTAPS.
    assign rd_sum  = {1'b0, head_q} + (TW+1)'(NTAPS - 1) - {1'b0, rd_tap};
    assign rd_idx  = (rd_sum >= (TW+1)'(NTAPS)) ? TW'(rd_sum - (TW+1)'(NTAPS)) : TW'(rd_sum);
    assign rd_data = mem_q[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '{default: '0};
            head_q <= '0;
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
        end
    end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Sequences one sample per pass through an external MAC: clear, NTAPS taps, capture, present.
// Optional FIR_SEQ_STALL_CNT_EN adds a saturating input-stall counter output.
module fir_tap_sequencer
    import fir_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NTAPS = 8,
    localparam int TW = tap_w(NTAPS)
) (
    input  logic                    Clk_CI,
    input  logic                    Rst_RBI,
    input  logic signed [WIDTH-1:0] In_DI,
    input  logic                    InValid_SI,
    output logic                    InReady_SO,
    input  logic                    CoefWrEn_SI,
    input  logic [TW-1:0]           CoefAddr_SI,
    input  logic signed [WIDTH-1:0] Coef_DI,
    output logic                    MacClr_SO,
    output logic                    MacWrEn_SO,
    output logic signed [WIDTH-1:0] MacIn0_DO,
    output logic signed [WIDTH-1:0] MacIn1_DO,
    input  logic signed [WIDTH-1:0] MacOut_DI,
    output logic signed [WIDTH-1:0] Out_DO,
    output logic                    OutValid_SO,
    input  logic                    OutReady_SI
`ifdef FIR_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]             StallCnt_DO
`endif
);

    state_e                  state_q, state_d;
    logic [TW-1:0]           tap_q, tap_d, tap_nxt, rd_tap;
    logic                    in_ready_q, in_ready_d;
    logic                    mac_clr_q, mac_clr_d, mac_wr_q, mac_wr_d;
    logic                    out_vld_q, out_vld_d;
    logic signed [WIDTH-1:0] in0_q, in0_d, in1_q, in1_d, out_q, out_d, rd_data;
    logic signed [WIDTH-1:0] coef_q [NTAPS];
    logic signed [WIDTH-1:0] coef_d [NTAPS];
    logic                    xfer;

    assign xfer    = (state_q == ST_IDLE) && in_ready_q && InValid_SI;
    assign tap_nxt = (tap_q == TW'(NTAPS - 1)) ? '0 : tap_q + 1'b1;
    // Operands are registered, so look up the tap that becomes current at the next edge.
    assign rd_tap  = (state_q == ST_ACCUM) ? tap_nxt : '0;

    fir_delay_line #(
        .WIDTH (WIDTH),
        .NTAPS (NTAPS)
    ) u_delay_line (
        .clk     (Clk_CI),
        .rst_n   (Rst_RBI),
        .wr_en   (xfer),
        .wr_data (In_DI),
        .rd_tap  (rd_tap),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d    = state_q;
        tap_d      = tap_q;
        in_ready_d = in_ready_q;
        mac_clr_d  = 1'b0;
        mac_wr_d   = 1'b0;
        in0_d      = '0;
        in1_d      = '0;
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        coef_d     = coef_q;
        case (state_q)
            ST_IDLE: begin
                in_ready_d = 1'b1;
                // Lands at the same edge as a transfer, so the sample sees the new value.
                if (CoefWrEn_SI && (32'(CoefAddr_SI) < NTAPS))
                    coef_d[CoefAddr_SI] = Coef_DI;
                if (xfer) begin
                    in_ready_d = 1'b0;
                    mac_clr_d  = 1'b1;
                    mac_wr_d   = 1'b1;
                    state_d    = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d  = ST_ACCUM;
                tap_d    = '0;
                mac_wr_d = 1'b1;
                in0_d    = rd_data;
                in1_d    = coef_q[rd_tap];
            end
            ST_ACCUM: begin
                if (tap_q == TW'(NTAPS - 1)) begin
                    state_d = ST_CAPTURE;
                end else begin
                    tap_d    = tap_nxt;
                    mac_wr_d = 1'b1;
                    in0_d    = rd_data;
                    in1_d    = coef_q[rd_tap];
                end
            end
            ST_CAPTURE: begin
                state_d   = ST_OUT;
                out_d     = MacOut_DI;
                out_vld_d = 1'b1;
            end
            ST_OUT: begin
                if (OutReady_SI) begin
                    out_vld_d  = 1'b0;
                    in_ready_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q    <= ST_IDLE;
            tap_q      <= '0;
            in_ready_q <= 1'b0;
            mac_clr_q  <= 1'b0;
            mac_wr_q   <= 1'b0;
            in0_q      <= '0;
            in1_q      <= '0;
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            coef_q     <= '{default: '0};
        end else begin
            state_q    <= state_d;
            tap_q      <= tap_d;
            in_ready_q <= in_ready_d;
            mac_clr_q  <= mac_clr_d;
            mac_wr_q   <= mac_wr_d;
            in0_q      <= in0_d;
            in1_q      <= in1_d;
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            coef_q     <= coef_d;
        end
    end

    assign InReady_SO  = in_ready_q;
    assign MacClr_SO   = mac_clr_q;
    assign MacWrEn_SO  = mac_wr_q;
    assign MacIn0_DO   = in0_q;
    assign MacIn1_DO   = in1_q;
    assign Out_DO      = out_q;
    assign OutValid_SO = out_vld_q;

`ifdef FIR_SEQ_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (InValid_SI && !in_ready_q && (stall_q != 16'hFFFF))
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) stall_q <= '0;
        else          stall_q <= stall_d;
    end

    assign StallCnt_DO = stall_q;
`endif

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer: behavioural MAC on MacOut_DI, scoreboarded operands and results.
module tb_fir_tap_sequencer;
    localparam int W = 16;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic signed [W-1:0] in_d = '0, coef_v = '0, mac_out, mac_in0, mac_in1, out_d;
    logic in_vld = 1'b0, coef_we = 1'b0, out_rdy = 1'b1;
    logic in_rdy, mac_clr, mac_we, out_vld;
    logic [1:0] coef_addr = '0;

    logic signed [W-1:0] d5_in = '0, d5_coef = '0, d5_in0, d5_in1, d5_out;
    logic d5_vld = 1'b0, d5_we = 1'b0, d5_rdy, d5_clr, d5_mwe, d5_ovld;
    logic [2:0] d5_addr = '0;
`ifdef FIR_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt, d5_stall;
`endif

    fir_tap_sequencer #(.WIDTH(W), .NTAPS(N)) u_dut (
        .Clk_CI(clk), .Rst_RBI(rst_n), .In_DI(in_d), .InValid_SI(in_vld), .InReady_SO(in_rdy),
        .CoefWrEn_SI(coef_we), .CoefAddr_SI(coef_addr), .Coef_DI(coef_v),
        .MacClr_SO(mac_clr), .MacWrEn_SO(mac_we), .MacIn0_DO(mac_in0), .MacIn1_DO(mac_in1),
        .MacOut_DI(mac_out), .Out_DO(out_d), .OutValid_SO(out_vld), .OutReady_SI(out_rdy)
`ifdef FIR_SEQ_STALL_CNT_EN
        , .StallCnt_DO(stall_cnt)
`endif
    );

    // Five-tap instance: lets an address beyond NTAPS be expressed on the address port.
    fir_tap_sequencer #(.WIDTH(W), .NTAPS(5)) u_dut5 (
        .Clk_CI(clk), .Rst_RBI(rst_n), .In_DI(d5_in), .InValid_SI(d5_vld), .InReady_SO(d5_rdy),
        .CoefWrEn_SI(d5_we), .CoefAddr_SI(d5_addr), .Coef_DI(d5_coef),
        .MacClr_SO(d5_clr), .MacWrEn_SO(d5_mwe), .MacIn0_DO(d5_in0), .MacIn1_DO(d5_in1),
        .MacOut_DI('0), .Out_DO(d5_out), .OutValid_SO(d5_ovld), .OutReady_SI(1'b1)
`ifdef FIR_SEQ_STALL_CNT_EN
        , .StallCnt_DO(d5_stall)
`endif
    );

    // Downstream accumulator model.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      mac_out <= '0;
        else if (mac_we) mac_out <= mac_clr ? '0 : mac_out + mac_in0 * mac_in1;
    end

    int total = 0;
    int bad = 0;
    logic [2*W-1:0]      exp_ops[$];
    logic signed [W-1:0] exp_out[$];
    logic signed [W-1:0] hist[N];
    logic signed [W-1:0] coef_m[N];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            hist[k] = '0;
            coef_m[k] = '0;
        end
        exp_ops.delete();
        exp_out.delete();
    endtask

    task automatic push_sample(input logic signed [W-1:0] s);
        logic signed [W-1:0] acc;
        for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = s;
        acc = '0;
        for (int k = 0; k < N; k++) begin
            exp_ops.push_back({hist[k], coef_m[k]});
            acc = acc + hist[k] * coef_m[k];
        end
        exp_out.push_back(acc);
    endtask

    task automatic write_coef(input logic [1:0] a, input logic signed [W-1:0] v, input bit taken);
        coef_we = 1'b1; coef_addr = a; coef_v = v;
        if (taken) coef_m[a] = v;
        @(posedge clk); #1;
        coef_we = 1'b0;
    endtask

    task automatic send(input logic signed [W-1:0] s);
        int n = 0;
        in_d = s; in_vld = 1'b1;
        while (!in_rdy && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) chk("send_timeout", 16'd0, 16'd1);
        push_sample(s);
        @(posedge clk); #1;
        in_vld = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_out.size() != 0 || exp_ops.size() != 0) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("drain_timeout", 16'(n < 200), 16'd1);
    endtask

    // Monitor: operands per tap, clear strobe, output stability and handshake value.
    logic [2*W-1:0]      p;
    logic                prev_vld = 1'b0;
    logic signed [W-1:0] prev_out = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (mac_we && !mac_clr) begin
                if (exp_ops.size() == 0) chk("op_unexpected", 16'd1, 16'd0);
                else begin
                    p = exp_ops.pop_front();
                    chk("op_in0", mac_in0, p[2*W-1:W]);
                    chk("op_in1", mac_in1, p[W-1:0]);
                end
            end
            if (mac_clr) begin
                chk("clr_we", 16'(mac_we), 16'd1);
                chk("clr_in0", mac_in0, 16'd0);
                chk("clr_in1", mac_in1, 16'd0);
            end
            if (mac_we || out_vld) chk("rdy_busy", 16'(in_rdy), 16'd0);
            if (out_vld && prev_vld) chk("out_stable", out_d, prev_out);
            if (out_vld && out_rdy) begin
                if (exp_out.size() == 0) chk("out_unexpected", 16'd1, 16'd0);
                else chk("out_val", out_d, exp_out.pop_front());
            end
            prev_vld = out_vld;
            prev_out = out_d;
        end else begin
            prev_vld = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_rdy", 16'(in_rdy), 16'd0);
        chk("rst_clr", 16'(mac_clr), 16'd0);
        chk("rst_we", 16'(mac_we), 16'd0);
        chk("rst_in0", mac_in0, 16'd0);
        chk("rst_in1", mac_in1, 16'd0);
        chk("rst_out", out_d, 16'd0);
        chk("rst_vld", 16'(out_vld), 16'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_rdy", 16'(in_rdy), 16'd1);
        chk("idle_vld", 16'(out_vld), 16'd0);
        chk("idle_out", out_d, 16'd0);

        // Out-of-range coefficient addresses on the five-tap instance.
        d5_we = 1'b1; d5_addr = 3'd4; d5_coef = 16'sd7;  @(posedge clk); #1;
        d5_addr = 3'd5; d5_coef = 16'sd9;  @(posedge clk); #1;
        d5_addr = 3'd7; d5_coef = 16'sd11; @(posedge clk); #1;
        d5_we = 1'b0;
        d5_in = 16'sd3; d5_vld = 1'b1;
        chk("d5_rdy", 16'(d5_rdy), 16'd1);
        @(posedge clk); #1;
        d5_vld = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("oob_in1", d5_in1, (k == 4) ? 16'sd7 : 16'sd0);
            chk("oob_in0", d5_in0, (k == 0) ? 16'sd3 : 16'sd0);
        end

        // Impulse through coefficients 1..4.
        for (int k = 0; k < N; k++) write_coef(2'(k), 16'(k + 1), 1'b1);
        send(16'sd100); send(16'sd0); send(16'sd0); send(16'sd0);
        drain();

        // Latency: valid at E+6, ready again at E+7.
        send(-16'sd3);
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            chk("lat_vld", 16'(out_vld), 16'(i == 6));
        end
        @(posedge clk); #1;
        chk("lat_rdy", 16'(in_rdy), 16'd1);
        drain();

        // Output backpressure with input held valid.
        out_rdy = 1'b0;
        send(16'sd55);
        for (int n = 0; n < 20 && !out_vld; n++) begin @(posedge clk); #1; end
        chk("bp_reach_out", 16'(out_vld), 16'd1);
        begin
`ifdef FIR_SEQ_STALL_CNT_EN
            logic [15:0] st0;
            st0 = stall_cnt;
`endif
            in_d = 16'sd99; in_vld = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                chk("bp_out", out_d, exp_out[0]);
                chk("bp_rdy", 16'(in_rdy), 16'd0);
                chk("bp_vld", 16'(out_vld), 16'd1);
            end
`ifdef FIR_SEQ_STALL_CNT_EN
            chk("stall_cnt", stall_cnt, st0 + 16'd10);
`endif
        end
        in_vld = 1'b0; out_rdy = 1'b1;
        drain();

        // Coefficient write during ACCUM is dropped; the same write in IDLE sticks.
        send(16'sd10);
        @(posedge clk); #1;
        write_coef(2'd2, 16'sd50, 1'b0);
        drain();
        write_coef(2'd2, 16'sd9, 1'b1);
        send(16'sd1); send(16'sd2);
        drain();

        // Coefficient write in the transfer cycle applies to that sample.
        coef_we = 1'b1; coef_addr = 2'd3; coef_v = -16'sd2;
        coef_m[3] = -16'sd2;
        send(16'sd20);
        coef_we = 1'b0;
        send(-16'sd7);
        drain();

        // Reset pulse during ACCUM tap 2.
        send(16'sd77);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_rdy", 16'(in_rdy), 16'd0);
        chk("mid_rst_we", 16'(mac_we), 16'd0);
        chk("mid_rst_in0", mac_in0, 16'd0);
        chk("mid_rst_out", out_d, 16'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("post_rst_novld", 16'(out_vld), 16'd0);
        end
        chk("post_rst_rdy", 16'(in_rdy), 16'd1);
        for (int k = 0; k < N; k++) write_coef(2'(k), 16'(k + 5), 1'b1);
        send(16'sd5); send(16'sd6);
        drain();

        chk("ops_left", 16'(exp_ops.size()), 16'd0);
        chk("outs_left", 16'(exp_out.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_tap_sequencer.md
FIR_TAP_SEQUENCER -- requirements
Module: fir_tap_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16: sample, coefficient and accumulator width.
REQ-002 SHALL have parameter NTAPS, default 8, legal 2..64: filter tap count.
REQ-003 Clk_CI  in  1  single clock; all state on rising edge.
REQ-004 Rst_RBI  in  1  asynchronous, active-low reset.
REQ-005 In_DI  in  WIDTH  signed input sample.
REQ-006 InValid_SI / InReady_SO  in/out  1  input handshake; transfer when both high.
REQ-007 CoefWrEn_SI, CoefAddr_SI [clog2(NTAPS)], Coef_DI [WIDTH]  in  coefficient write port.
REQ-008 MacClr_SO, MacWrEn_SO  out  1  drive downstream accumulator clear/write-enable.
REQ-009 MacIn0_DO, MacIn1_DO  out  WIDTH  signed sample/coefficient operands to accumulator.
REQ-010 MacOut_DI  in  WIDTH  signed accumulator result.
REQ-011 Out_DO  out  WIDTH; OutValid_SO out 1; OutReady_SI in 1  output handshake.

Function
REQ-012 SHALL implement FSM IDLE -> CLEAR -> ACCUM -> CAPTURE -> OUT -> IDLE.
REQ-013 IDLE: InReady_SO=1; on transfer, write sample at head pointer, advance head (wrap NTAPS-1 -> 0), go CLEAR.
REQ-014 CLEAR: one cycle, MacClr_SO=1, MacWrEn_SO=1, operands zero.
REQ-015 ACCUM: NTAPS cycles, tap k=0..NTAPS-1; MacWrEn_SO=1, MacClr_SO=0, MacIn0_DO=x[n-k] (newest sample first, index wraps modulo NTAPS), MacIn1_DO=coef[k].
REQ-016 CAPTURE: one cycle, Mac strobes low; Out_DO registered from MacOut_DI at cycle end.
REQ-017 OUT: OutValid_SO=1, Out_DO stable until OutReady_SI=1, then IDLE.
REQ-018 Latency: input transfer at edge E -> OutValid_SO high from edge E+NTAPS+2; throughput one sample per NTAPS+3 cycles when OutReady_SI held high.
REQ-019 InReady_SO SHALL be 0 in every state except IDLE; no input buffering.
REQ-020 Coefficient write SHALL take effect only in IDLE; writes in other states or with CoefAddr_SI>=NTAPS SHALL be ignored.
REQ-021 Coefficient write and input transfer in the same IDLE cycle: coefficient write first; new coefficient used for that sample.
REQ-022 OutValid_SO SHALL not drop before handshake; Out_DO SHALL not change while OutValid_SO=1.

Reset
REQ-023 Rst_RBI low, any state: FSM IDLE, head pointer 0, delay line and coefficients 0, Out_DO 0, OutValid_SO 0, MacClr_SO 0, MacWrEn_SO 0, operands 0, InReady_SO 0 while reset asserted.
REQ-024 Reset mid-ACCUM SHALL abandon the sample; no output produced.

Configuration
REQ-025 Macro FIR_SEQ_STALL_CNT_EN defined: adds output StallCnt_DO [16], counting cycles with InValid_SI=1 and InReady_SO=0, saturating at 16'hFFFF, reset 0.
REQ-026 Macro undefined: port and counter absent; all other behaviour identical.

Structure
REQ-027 Package fir_seq_pkg SHALL hold the FSM state enum and tap-index width constant.
REQ-028 Circular delay line SHALL be sub-module fir_delay_line (write port, head pointer, tap-indexed read).

Verification (WIDTH=16, NTAPS=4, behavioural accumulator model on MacOut_DI)
REQ-029 Reset then idle -> all outputs 0, InReady_SO=1 after deassertion.
REQ-030 Coefs {1,2,3,4}, input 100 then 0,0,0 -> MacIn1_DO sequence 1,2,3,4 per sample; MacIn0_DO sample 1 = 100,0,0,0; sample 4 = 0,0,0,100.
REQ-031 Input transfer at edge E, OutReady_SI=1 -> OutValid_SO high at E+6, InReady_SO high at E+7.
REQ-032 OutReady_SI held 0 for 10 cycles -> Out_DO constant, InReady_SO=0, InValid_SI ignored.
REQ-033 Coefficient write to addr 2 during ACCUM -> ignored; same write in IDLE -> used on next sample; write to addr 5 -> ignored.
REQ-034 Rst_RBI pulsed low during ACCUM tap 2 -> IDLE, delay line zero, no OutValid_SO.
